// File: rtl/fetch_queue.sv
// fetch_queue: valid/ready prefetch FIFO of {instr, pc} pairs with a sequential fetch PC and redirect flush.
// Define FETCH_QUEUE_BYPASS_EN for a zero-latency push->pop path when the queue is empty.
module fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] PC_RESET = 32'h0
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       flush,
  input  logic [XLEN-1:0]            flush_pc,
  output logic [XLEN-1:0]            fetch_pc,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [XLEN-1:0]            push_instr,
  output logic                       pop_valid,
  input  logic                       pop_ready,
  output logic [XLEN-1:0]            pop_instr,
  output logic [XLEN-1:0]            pop_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned   PW       = $clog2(DEPTH);
  localparam int unsigned   CW       = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [XLEN-1:0] instr_mem_r [DEPTH];
  logic [XLEN-1:0] pc_mem_r    [DEPTH];
  logic [PW-1:0]   wptr_r;
  logic [PW-1:0]   rptr_r;
  logic [CW-1:0]   count_r;
  logic [XLEN-1:0] fetch_pc_r;

  logic push_acc_s;
  logic pop_acc_s;
  logic q_valid_s;
  logic bypass_s;
  logic bypass_take_s;
  logic wr_s;
  logic rd_s;
  logic unused_pc_lsb_s;

  assign unused_pc_lsb_s = ^flush_pc[1:0];
  assign fetch_pc        = fetch_pc_r;
  assign count           = count_r;

  // Handshake decode, bypass selection and head-entry output mux
  always_comb begin
    push_ready = (count_r != FULL_CNT);
    push_acc_s = push_valid && push_ready && !flush;
    q_valid_s  = (count_r != {CW{1'b0}}) && !flush;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass_s   = (count_r == {CW{1'b0}}) && push_valid && !flush;
`else
    bypass_s   = 1'b0;
`endif
    pop_valid     = q_valid_s || bypass_s;
    pop_acc_s     = pop_valid && pop_ready && !flush;
    // A consumed bypass word never touches storage or the pointers
    bypass_take_s = bypass_s && pop_ready;
    wr_s          = push_acc_s && !bypass_take_s;
    rd_s          = pop_acc_s && !bypass_take_s;
    if (bypass_s) begin
      pop_instr = push_instr;
      pop_pc    = fetch_pc_r;
    end else if (q_valid_s) begin
      pop_instr = instr_mem_r[rptr_r];
      pop_pc    = pc_mem_r[rptr_r];
    end else begin
      pop_instr = {XLEN{1'b0}};
      pop_pc    = {XLEN{1'b0}};
    end
  end

  // Pointers, occupancy and fetch PC; flush overrides any handshake
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr_r     <= {PW{1'b0}};
      rptr_r     <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      fetch_pc_r <= PC_RESET;
    end else if (flush) begin
      wptr_r     <= {PW{1'b0}};
      rptr_r     <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      fetch_pc_r <= {flush_pc[XLEN-1:2], 2'b00};
    end else begin
      if (wr_s) begin
        wptr_r <= wptr_r + PW'(1'b1);
      end
      if (rd_s) begin
        rptr_r <= rptr_r + PW'(1'b1);
      end
      if (push_acc_s) begin
        fetch_pc_r <= fetch_pc_r + XLEN'(3'd4);
      end
      case ({wr_s, rd_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents survive flush and reset, validity comes from count
  always_ff @(posedge clk) begin
    if (wr_s) begin
      instr_mem_r[wptr_r] <= push_instr;
      pc_mem_r[wptr_r]    <= fetch_pc_r;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4); a second instance covers PC_RESET=32'hFFFFFFF8 wrap.
module tb_fetch_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst, flush, push_valid, pop_ready, push_ready, pop_valid;
  logic [31:0] flush_pc, push_instr, fetch_pc, pop_instr, pop_pc;
  logic [2:0]  count;

  logic        w_push_valid, w_pop_ready, w_push_ready, w_pop_valid;
  logic [31:0] w_push_instr, w_fetch_pc, w_pop_instr, w_pop_pc;
  logic [2:0]  w_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  fetch_queue #(.XLEN(32), .DEPTH(4), .PC_RESET(32'h0)) dut (
    .clk(clk), .nrst(nrst), .flush(flush), .flush_pc(flush_pc), .fetch_pc(fetch_pc),
    .push_valid(push_valid), .push_ready(push_ready), .push_instr(push_instr),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_instr(pop_instr), .pop_pc(pop_pc),
    .count(count)
  );

  fetch_queue #(.XLEN(32), .DEPTH(4), .PC_RESET(32'hFFFFFFF8)) dut_wrap (
    .clk(clk), .nrst(nrst), .flush(1'b0), .flush_pc(32'h0), .fetch_pc(w_fetch_pc),
    .push_valid(w_push_valid), .push_ready(w_push_ready), .push_instr(w_push_instr),
    .pop_valid(w_pop_valid), .pop_ready(w_pop_ready), .pop_instr(w_pop_instr), .pop_pc(w_pop_pc),
    .count(w_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b0; flush = 1'b0; flush_pc = 32'h0; push_valid = 1'b0; push_instr = 32'h0; pop_ready = 1'b0;
    w_push_valid = 1'b0; w_push_instr = 32'h0; w_pop_ready = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    push_valid = 1'b1; push_instr = 32'h00000013; step(); push_valid = 1'b0;
    total_cnt++; if (count !== 3'd1) $display("FAIL pre_reset_count: got %0d want 1", count); else pass_cnt++;
    #2 nrst = 1'b0;
    #1;
    total_cnt++; if (count !== 3'd0) $display("FAIL rst_count: got %0d want 0", count); else pass_cnt++;
    total_cnt++; if (fetch_pc !== 32'h0) $display("FAIL rst_fetch_pc: got %h want 0", fetch_pc); else pass_cnt++;
    total_cnt++; if (pop_valid !== 1'b0) $display("FAIL rst_pop_valid: got %b want 0", pop_valid); else pass_cnt++;
    total_cnt++; if (pop_instr !== 32'h0) $display("FAIL rst_pop_instr: got %h want 0", pop_instr); else pass_cnt++;
    total_cnt++; if (pop_pc !== 32'h0) $display("FAIL rst_pop_pc: got %h want 0", pop_pc); else pass_cnt++;
    total_cnt++; if (push_ready !== 1'b1) $display("FAIL rst_push_ready: got %b want 1", push_ready); else pass_cnt++;
    total_cnt++; if (w_fetch_pc !== 32'hFFFFFFF8) $display("FAIL rst_wrap_fetch_pc: got %h want fffffff8", w_fetch_pc); else pass_cnt++;
    @(negedge clk);
    nrst = 1'b1;
    step();
  endtask

  task automatic test_push_pop();
    logic [31:0] words [3];
    words[0] = 32'h3e800093; words[1] = 32'h83000113; words[2] = 32'h3e906193;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push_valid = 1'b1; push_instr = words[i]; step();
      total_cnt++; if (count !== 3'(i + 1)) $display("FAIL pp_count%0d: got %0d want %0d", i, count, i + 1); else pass_cnt++;
      total_cnt++; if (fetch_pc !== 32'(4 * (i + 1))) $display("FAIL pp_fetch_pc%0d: got %h want %h", i, fetch_pc, 4 * (i + 1)); else pass_cnt++;
    end
    push_valid = 1'b0; pop_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++; if (pop_valid !== 1'b1) $display("FAIL pp_pop_valid%0d: got %b want 1", i, pop_valid); else pass_cnt++;
      total_cnt++; if (pop_instr !== words[i]) $display("FAIL pp_pop_instr%0d: got %h want %h", i, pop_instr, words[i]); else pass_cnt++;
      total_cnt++; if (pop_pc !== 32'(4 * i)) $display("FAIL pp_pop_pc%0d: got %h want %h", i, pop_pc, 4 * i); else pass_cnt++;
      step();
    end
    pop_ready = 1'b0;
    total_cnt++; if (count !== 3'd0) $display("FAIL pp_drained: got %0d want 0", count); else pass_cnt++;
    total_cnt++; if (pop_valid !== 1'b0) $display("FAIL pp_empty_valid: got %b want 0", pop_valid); else pass_cnt++;
  endtask

  task automatic test_full();
    logic [31:0] exp_instr;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_valid = 1'b1; push_instr = 32'hA0 + 32'(i); step();
    end
    total_cnt++; if (count !== 3'd4) $display("FAIL full_count: got %0d want 4", count); else pass_cnt++;
    total_cnt++; if (push_ready !== 1'b0) $display("FAIL full_push_ready: got %b want 0", push_ready); else pass_cnt++;
    push_instr = 32'hBEEF0005; step();
    total_cnt++; if (count !== 3'd4) $display("FAIL full_hold_count: got %0d want 4", count); else pass_cnt++;
    total_cnt++; if (fetch_pc !== 32'h10) $display("FAIL full_hold_pc: got %h want 10", fetch_pc); else pass_cnt++;
    pop_ready = 1'b1; step(); pop_ready = 1'b0;
    total_cnt++; if (count !== 3'd3) $display("FAIL full_pop_count: got %0d want 3", count); else pass_cnt++;
    total_cnt++; if (push_ready !== 1'b1) $display("FAIL full_reopen: got %b want 1", push_ready); else pass_cnt++;
    total_cnt++; if (fetch_pc !== 32'h10) $display("FAIL full_pop_pc: got %h want 10", fetch_pc); else pass_cnt++;
    step(); push_valid = 1'b0;
    total_cnt++; if (count !== 3'd4) $display("FAIL full_held_count: got %0d want 4", count); else pass_cnt++;
    total_cnt++; if (fetch_pc !== 32'h14) $display("FAIL full_held_pc: got %h want 14", fetch_pc); else pass_cnt++;
    pop_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_instr = (i == 3) ? 32'hBEEF0005 : 32'hA0 + 32'(i + 1);
      #1;
      total_cnt++; if (pop_instr !== exp_instr) $display("FAIL full_drain_instr%0d: got %h want %h", i, pop_instr, exp_instr); else pass_cnt++;
      total_cnt++; if (pop_pc !== 32'(4 * (i + 1))) $display("FAIL full_drain_pc%0d: got %h want %h", i, pop_pc, 4 * (i + 1)); else pass_cnt++;
      step();
    end
    pop_ready = 1'b0;
    total_cnt++; if (count !== 3'd0) $display("FAIL full_drained: got %0d want 0", count); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      push_valid = 1'b1; push_instr = 32'h1000 + 32'(i); step();
    end
    pop_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      push_instr = 32'h1000 + 32'(k + 2);
      #1;
      total_cnt++; if (pop_instr !== 32'h1000 + 32'(k)) $display("FAIL b2b_instr%0d: got %h want %h", k, pop_instr, 32'h1000 + k); else pass_cnt++;
      total_cnt++; if (pop_pc !== 32'(4 * k)) $display("FAIL b2b_pc%0d: got %h want %h", k, pop_pc, 4 * k); else pass_cnt++;
      step();
      total_cnt++; if (count !== 3'd2) $display("FAIL b2b_count%0d: got %0d want 2", k, count); else pass_cnt++;
    end
    push_valid = 1'b0;
    for (int k = 10; k < 12; k++) begin
      #1;
      total_cnt++; if (pop_pc !== 32'(4 * k)) $display("FAIL b2b_tail_pc%0d: got %h want %h", k, pop_pc, 4 * k); else pass_cnt++;
      step();
    end
    pop_ready = 1'b0;
    total_cnt++; if (count !== 3'd0) $display("FAIL b2b_drained: got %0d want 0", count); else pass_cnt++;
    total_cnt++; if (fetch_pc !== 32'd48) $display("FAIL b2b_fetch_pc: got %h want 30", fetch_pc); else pass_cnt++;
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push_valid = 1'b1; push_instr = 32'h2000 + 32'(i); step();
    end
    flush = 1'b1; flush_pc = 32'h3e9; push_instr = 32'hDEAD0000; pop_ready = 1'b1;
    #1;
    total_cnt++; if (pop_valid !== 1'b0) $display("FAIL flush_pop_valid: got %b want 0", pop_valid); else pass_cnt++;
    total_cnt++; if (pop_instr !== 32'h0) $display("FAIL flush_pop_instr: got %h want 0", pop_instr); else pass_cnt++;
    step();
    flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
    total_cnt++; if (count !== 3'd0) $display("FAIL flush_count: got %0d want 0", count); else pass_cnt++;
    total_cnt++; if (pop_valid !== 1'b0) $display("FAIL flush_next_valid: got %b want 0", pop_valid); else pass_cnt++;
    total_cnt++; if (fetch_pc !== 32'h3e8) $display("FAIL flush_fetch_pc: got %h want 3e8", fetch_pc); else pass_cnt++;
    push_valid = 1'b1; push_instr = 32'h00500093; step(); push_valid = 1'b0;
    total_cnt++; if (pop_valid !== 1'b1) $display("FAIL flush_post_valid: got %b want 1", pop_valid); else pass_cnt++;
    total_cnt++; if (pop_pc !== 32'h3e8) $display("FAIL flush_post_pc: got %h want 3e8", pop_pc); else pass_cnt++;
    total_cnt++; if (pop_instr !== 32'h00500093) $display("FAIL flush_post_instr: got %h want 00500093", pop_instr); else pass_cnt++;
    total_cnt++; if (fetch_pc !== 32'h3ec) $display("FAIL flush_post_fetch: got %h want 3ec", fetch_pc); else pass_cnt++;
    pop_ready = 1'b1; step(); pop_ready = 1'b0;
  endtask

  task automatic test_pc_wrap();
    do_reset();
    w_push_valid = 1'b1; w_push_instr = 32'h11; step();
    w_push_instr = 32'h22; step(); w_push_valid = 1'b0;
    total_cnt++; if (w_fetch_pc !== 32'h0) $display("FAIL wrap_fetch_pc: got %h want 0", w_fetch_pc); else pass_cnt++;
    total_cnt++; if (w_count !== 3'd2) $display("FAIL wrap_count: got %0d want 2", w_count); else pass_cnt++;
    w_pop_ready = 1'b1;
    #1;
    total_cnt++; if (w_pop_pc !== 32'hFFFFFFF8) $display("FAIL wrap_pc0: got %h want fffffff8", w_pop_pc); else pass_cnt++;
    total_cnt++; if (w_pop_instr !== 32'h11) $display("FAIL wrap_instr0: got %h want 11", w_pop_instr); else pass_cnt++;
    step();
    total_cnt++; if (w_pop_pc !== 32'hFFFFFFFC) $display("FAIL wrap_pc1: got %h want fffffffc", w_pop_pc); else pass_cnt++;
    total_cnt++; if (w_pop_instr !== 32'h22) $display("FAIL wrap_instr1: got %h want 22", w_pop_instr); else pass_cnt++;
    step(); w_pop_ready = 1'b0;
    total_cnt++; if (w_count !== 3'd0) $display("FAIL wrap_drained: got %0d want 0", w_count); else pass_cnt++;
  endtask

  task automatic test_bypass();
    do_reset();
    push_valid = 1'b1; push_instr = 32'h00111263; pop_ready = 1'b1;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    total_cnt++; if (pop_valid !== 1'b1) $display("FAIL byp_valid: got %b want 1", pop_valid); else pass_cnt++;
    total_cnt++; if (pop_instr !== 32'h00111263) $display("FAIL byp_instr: got %h want 00111263", pop_instr); else pass_cnt++;
    total_cnt++; if (pop_pc !== 32'h0) $display("FAIL byp_pc: got %h want 0", pop_pc); else pass_cnt++;
    step(); push_valid = 1'b0;
    total_cnt++; if (count !== 3'd0) $display("FAIL byp_count: got %0d want 0", count); else pass_cnt++;
    total_cnt++; if (fetch_pc !== 32'h4) $display("FAIL byp_fetch_pc: got %h want 4", fetch_pc); else pass_cnt++;
    total_cnt++; if (pop_valid !== 1'b0) $display("FAIL byp_after_valid: got %b want 0", pop_valid); else pass_cnt++;
`else
    total_cnt++; if (pop_valid !== 1'b0) $display("FAIL nobyp_valid: got %b want 0", pop_valid); else pass_cnt++;
    step(); push_valid = 1'b0;
    total_cnt++; if (count !== 3'd1) $display("FAIL nobyp_count1: got %0d want 1", count); else pass_cnt++;
    total_cnt++; if (pop_valid !== 1'b1) $display("FAIL nobyp_next_valid: got %b want 1", pop_valid); else pass_cnt++;
    total_cnt++; if (pop_instr !== 32'h00111263) $display("FAIL nobyp_instr: got %h want 00111263", pop_instr); else pass_cnt++;
    step();
    total_cnt++; if (count !== 3'd0) $display("FAIL nobyp_count0: got %0d want 0", count); else pass_cnt++;
`endif
    pop_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_full();
    test_back_to_back();
    test_flush();
    test_pc_wrap();
    test_bypass();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
